// File: rtl/bot_actuator_driver.sv
// Decodes the 3-bit navigation state into ramped PWM/direction for two motors,
// sequences timed U-turns and the gripper handshake, and reports done/fault.
module bot_actuator_driver #(
  parameter int PWM_BITS     = 8,
  parameter int DUTY_FWD     = 200,
  parameter int DUTY_TURN    = 128,
  parameter int RAMP_STEP    = 16,
  parameter int UTURN_CYCLES = 50000,
  parameter int PICK_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       gripper_ack,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       dir_left,
  output logic       dir_right,
  output logic       gripper_cmd,
  output logic       action_done,
  output logic       fault
);

  localparam logic [PWM_BITS-1:0] D_FWD   = PWM_BITS'(DUTY_FWD);
  localparam logic [PWM_BITS-1:0] D_TURN  = PWM_BITS'(DUTY_TURN);
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [23:0]         UT_LAST = 24'(UTURN_CYCLES - 1);
  localparam logic [23:0]         PT_LAST = 24'(PICK_TIMEOUT - 1);

  localparam logic [2:0] ST_DRIVE = 3'b001;
  localparam logic [2:0] ST_LEFT  = 3'b010;
  localparam logic [2:0] ST_RIGHT = 3'b011;
  localparam logic [2:0] ST_UTURN = 3'b100;
  localparam logic [2:0] ST_PICK  = 3'b101;

  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_UTURN, SEQ_PICK_STOP, SEQ_PICK_GRIP, SEQ_HOLD
  } seq_e;

  seq_e                seq_q;
  logic [2:0]          act_q;
  logic [23:0]         cnt_q;
  logic                grip_q, done_q, fault_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_l_q, duty_r_q, duty_l_d, duty_r_d;
  logic                dir_l_q, dir_r_q, dir_l_d, dir_r_d;
  logic                pwm_l_q, pwm_r_q;
  logic [PWM_BITS-1:0] tgt_l, tgt_r;
  logic                tdir_l, tdir_r;

  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] r;
    r = cur;
    if (cur < tgt)      r = ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else if (cur > tgt) r = ((cur - tgt) > STEP) ? cur - STEP : tgt;
    return r;
  endfunction

  // A zero-duty target keeps the current direction so idling never flips a motor.
  always_comb begin
    tgt_l  = '0;
    tgt_r  = '0;
    tdir_l = dir_l_q;
    tdir_r = dir_r_q;
    case (state)
      ST_DRIVE: begin
        tgt_l = D_FWD;  tdir_l = 1'b1;
        tgt_r = D_FWD;  tdir_r = 1'b1;
      end
      ST_LEFT:  begin tgt_r = D_TURN; tdir_r = 1'b1; end
      ST_RIGHT: begin tgt_l = D_TURN; tdir_l = 1'b1; end
      ST_UTURN: begin
        if (seq_q == SEQ_UTURN) begin
          tgt_l = D_TURN; tdir_l = 1'b0;
          tgt_r = D_TURN; tdir_r = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reversal: ramp to zero first, flip at a period end already at zero.
  always_comb begin
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    dir_l_d  = dir_l_q;
    dir_r_d  = dir_r_q;
    if (pwm_cnt_q == CNT_MAX) begin
      if (dir_l_q == tdir_l)   duty_l_d = step_toward(duty_l_q, tgt_l);
      else if (duty_l_q == '0) dir_l_d  = tdir_l;
      else                     duty_l_d = step_toward(duty_l_q, '0);
      if (dir_r_q == tdir_r)   duty_r_d = step_toward(duty_r_q, tgt_r);
      else if (duty_r_q == '0) dir_r_d  = tdir_r;
      else                     duty_r_d = step_toward(duty_r_q, '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      duty_l_q  <= '0;
      duty_r_q  <= '0;
      dir_l_q   <= 1'b1;
      dir_r_q   <= 1'b1;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      duty_l_q  <= duty_l_d;
      duty_r_q  <= duty_r_d;
      dir_l_q   <= dir_l_d;
      dir_r_q   <= dir_r_d;
      pwm_l_q   <= (pwm_cnt_q < duty_l_q);
      pwm_r_q   <= (pwm_cnt_q < duty_r_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q   <= SEQ_IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
      grip_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state[2:1] == 2'b11) fault_q <= 1'b1;
      case (seq_q)
        SEQ_IDLE: begin
          if (state == ST_UTURN) begin
            cnt_q <= '0;
            act_q <= state;
            seq_q <= SEQ_UTURN;
          end else if (state == ST_PICK) begin
            act_q <= state;
            seq_q <= SEQ_PICK_STOP;
          end
        end
        SEQ_UTURN: begin
          if (state != act_q) begin
            cnt_q <= '0;
            seq_q <= SEQ_IDLE;
          end else if (cnt_q == UT_LAST) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            seq_q  <= SEQ_HOLD;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        SEQ_PICK_STOP: begin
          if (state != act_q) begin
            cnt_q <= '0;
            seq_q <= SEQ_IDLE;
          end else if (duty_l_q == '0 && duty_r_q == '0) begin
            grip_q <= 1'b1;
            cnt_q  <= '0;
            seq_q  <= SEQ_PICK_GRIP;
          end
        end
        SEQ_PICK_GRIP: begin
          // Ack is tested before the timeout so a same-cycle ack wins.
          if (state != act_q) begin
            grip_q <= 1'b0;
            cnt_q  <= '0;
            seq_q  <= SEQ_IDLE;
          end else if (gripper_ack) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            seq_q  <= SEQ_HOLD;
          end else if (cnt_q == PT_LAST) begin
            fault_q <= 1'b1;
            grip_q  <= 1'b0;
            cnt_q   <= '0;
            seq_q   <= SEQ_HOLD;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        SEQ_HOLD: begin
          if (state != act_q) begin
            grip_q <= 1'b0;
            seq_q  <= SEQ_IDLE;
          end
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign pwm_left    = pwm_l_q;
  assign pwm_right   = pwm_r_q;
  assign dir_left    = dir_l_q;
  assign dir_right   = dir_r_q;
  assign gripper_cmd = grip_q;
  assign action_done = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_bot_actuator_driver.sv
// Directed bench for bot_actuator_driver with shortened U-turn and pickup timeouts.
module tb_bot_actuator_driver;

  localparam int UT = 8000;
  localparam int PT = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'b000;
  logic       gripper_ack = 1'b0;
  logic       pwm_left, pwm_right, dir_left, dir_right;
  logic       gripper_cmd, action_done, fault;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  bot_actuator_driver #(
    .PWM_BITS(8), .DUTY_FWD(200), .DUTY_TURN(128), .RAMP_STEP(16),
    .UTURN_CYCLES(UT), .PICK_TIMEOUT(PT)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .gripper_ack(gripper_ack),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .dir_left(dir_left), .dir_right(dir_right),
    .gripper_cmd(gripper_cmd), .action_done(action_done), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (action_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Returns at the negedge just after a ramp update (pwm_cnt back at 0).
  task automatic next_period;
    @(negedge clk);
    while (dut.pwm_cnt_q != 8'hFF) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #2;
    tests++;
    if ({pwm_left, pwm_right, dir_left, dir_right, gripper_cmd, action_done, fault} !== 7'b0011000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0011000",
               {pwm_left, pwm_right, dir_left, dir_right, gripper_cmd, action_done, fault});
    end
    tests++;
    if (dut.duty_l_q !== 8'd0 || dut.duty_r_q !== 8'd0) begin
      fails++;
      $display("FAIL reset_duty: got %0d/%0d expected 0/0", dut.duty_l_q, dut.duty_r_q);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_drive;
    int exp, hl, hr;
    next_period;
    state = 3'b001;
    for (int i = 1; i <= 13; i++) begin
      next_period;
      exp = (16 * i > 200) ? 200 : 16 * i;
      tests++;
      if (dut.duty_l_q !== 8'(exp) || dut.duty_r_q !== 8'(exp) || dir_left !== 1'b1 || dir_right !== 1'b1) begin
        fails++;
        $display("FAIL drive_ramp[%0d]: got duty %0d/%0d dir %b%b expected %0d/%0d dir 11",
                 i, dut.duty_l_q, dut.duty_r_q, dir_left, dir_right, exp, exp);
      end
    end
    hl = 0;
    hr = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_left)  hl++;
      if (pwm_right) hr++;
    end
    tests++;
    if (hl != 200 || hr != 200) begin
      fails++;
      $display("FAIL drive_pwm_high: got %0d/%0d expected 200/200", hl, hr);
    end
  endtask

  task automatic test_uturn;
    int ml, mdl, mr, c0, d0, k;
    next_period;
    state = 3'b100;
    c0 = cyc;
    d0 = done_cnt;
    ml = 200; mdl = 1; mr = 200;
    for (int i = 1; i <= 22; i++) begin
      next_period;
      if (mdl == 1) begin
        if (ml == 0) mdl = 0;
        else ml = (ml > 16) ? ml - 16 : 0;
      end else begin
        ml = (ml + 16 > 128) ? 128 : ml + 16;
      end
      mr = (mr - 16 < 128) ? 128 : mr - 16;
      tests++;
      if (dut.duty_l_q !== 8'(ml) || dir_left !== 1'(mdl) || dut.duty_r_q !== 8'(mr) || dir_right !== 1'b1) begin
        fails++;
        $display("FAIL uturn_ramp[%0d]: got L %0d/%b R %0d/%b expected L %0d/%0d R %0d/1",
                 i, dut.duty_l_q, dir_left, dut.duty_r_q, dir_right, ml, mdl, mr);
      end
    end
    tests++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL uturn_early_done: got %0d pulses expected 0", done_cnt - d0);
    end
    k = 0;
    while (done_cnt == d0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    #2;
    tests++;
    if (done_cnt != d0 + 1 || done_cyc - c0 != UT + 1) begin
      fails++;
      $display("FAIL uturn_done_time: got %0d pulses at +%0d expected 1 at +%0d",
               done_cnt - d0, done_cyc - c0, UT + 1);
    end
    repeat (1500) @(negedge clk);
    #2;
    tests++;
    if (done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL uturn_no_retrigger: got %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_pick;
    int k, d0;
    state = 3'b001;
    k = 0;
    while (!(dut.duty_l_q == 8'd200 && dut.duty_r_q == 8'd200 && dir_left && dir_right) && k < 50) begin
      next_period;
      k++;
    end
    tests++;
    if (k >= 50) begin
      fails++;
      $display("FAIL pick_prep_drive: got duty %0d/%0d expected 200/200", dut.duty_l_q, dut.duty_r_q);
    end
    next_period;
    state = 3'b101;
    d0 = done_cnt;
    k = 0;
    while (!gripper_cmd && k < 6000) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (gripper_cmd !== 1'b1 || dut.duty_l_q !== 8'd0 || dut.duty_r_q !== 8'd0 || k < 12 * 256) begin
      fails++;
      $display("FAIL pick_grip_rise: got cmd %b duty %0d/%0d after %0d clks expected cmd 1 duty 0/0",
               gripper_cmd, dut.duty_l_q, dut.duty_r_q, k);
    end
    repeat (10) @(negedge clk);
    gripper_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (action_done !== 1'b1) begin
      fails++;
      $display("FAIL pick_done_pulse: got %b expected 1", action_done);
    end
    gripper_ack = 1'b0;
    @(negedge clk);
    #2;
    tests++;
    if (action_done !== 1'b0 || gripper_cmd !== 1'b1 || done_cnt != d0 + 1) begin
      fails++;
      $display("FAIL pick_after_ack: got done %b cmd %b pulses %0d expected 0 1 1",
               action_done, gripper_cmd, done_cnt - d0);
    end
    @(negedge clk);
    state = 3'b000;
    @(negedge clk);
    tests++;
    if (gripper_cmd !== 1'b0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL pick_release: got cmd %b fault %b expected 0 0", gripper_cmd, fault);
    end
  endtask

  task automatic test_timeout;
    int k, g0, f0, d0;
    next_period;
    state = 3'b101;
    d0 = done_cnt;
    k = 0;
    while (!gripper_cmd && k < 1000) begin
      @(negedge clk);
      k++;
    end
    g0 = cyc;
    k = 0;
    while (!fault && k < PT + 100) begin
      @(negedge clk);
      k++;
    end
    f0 = cyc;
    tests++;
    if (fault !== 1'b1 || f0 - g0 != PT) begin
      fails++;
      $display("FAIL timeout_fault_time: got fault %b at +%0d expected 1 at +%0d", fault, f0 - g0, PT);
    end
    tests++;
    if (gripper_cmd !== 1'b0) begin
      fails++;
      $display("FAIL timeout_grip_drop: got %b expected 0", gripper_cmd);
    end
    repeat (5) @(negedge clk);
    #2;
    tests++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL timeout_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
    state = 3'b001;
    repeat (300) @(negedge clk);
    state = 3'b000;
    repeat (10) @(negedge clk);
    tests++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky: got %b expected 1", fault);
    end
  endtask

  task automatic test_abort;
    int k, c0, d0;
    do_reset;
    state = 3'b000;
    tests++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL abort_fault_cleared: got %b expected 0", fault);
    end
    next_period;
    state = 3'b100;
    d0 = done_cnt;
    repeat (1000) @(negedge clk);
    state = 3'b000;
    repeat (UT + 200) @(negedge clk);
    #2;
    tests++;
    if (done_cnt != d0 || dut.duty_l_q !== 8'd0 || dut.duty_r_q !== 8'd0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d pulses duty %0d/%0d expected 0 pulses duty 0/0",
               done_cnt - d0, dut.duty_l_q, dut.duty_r_q);
    end
    next_period;
    state = 3'b100;
    c0 = cyc;
    k = 0;
    while (done_cnt == d0 && k < UT + 500) begin
      @(negedge clk);
      k++;
    end
    #2;
    tests++;
    if (done_cnt != d0 + 1 || done_cyc - c0 != UT + 1) begin
      fails++;
      $display("FAIL abort_restart_count: got %0d pulses at +%0d expected 1 at +%0d",
               done_cnt - d0, done_cyc - c0, UT + 1);
    end
  endtask

  task automatic test_invalid_reset;
    do_reset;
    state = 3'b000;
    next_period;
    state = 3'b001;
    repeat (5) next_period;
    state = 3'b110;
    @(negedge clk);
    tests++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL invalid_fault: got %b expected 1", fault);
    end
    next_period;
    next_period;
    tests++;
    if (dut.duty_l_q !== 8'd48 || dut.duty_r_q !== 8'd48) begin
      fails++;
      $display("FAIL invalid_ramp_down: got %0d/%0d expected 48/48", dut.duty_l_q, dut.duty_r_q);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (pwm_left !== 1'b1) begin
      fails++;
      $display("FAIL invalid_pwm_active: got %b expected 1", pwm_left);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({pwm_left, pwm_right, dir_left, dir_right, gripper_cmd, action_done, fault} !== 7'b0011000 ||
        dut.duty_l_q !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got %b duty %0d expected 0011000 duty 0",
               {pwm_left, pwm_right, dir_left, dir_right, gripper_cmd, action_done, fault}, dut.duty_l_q);
    end
    @(negedge clk);
    reset = 1'b1;
    state = 3'b000;
  endtask

  initial begin
    test_reset;
    test_drive;
    test_uturn;
    test_pick;
    test_timeout;
    test_abort;
    test_invalid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bot_actuator_driver.md
Name: bot_actuator_driver

Overview:
- Consumer end of the controller's 3-bit navigation state bus.
- Decodes IDLE/DRIVE_BOTH/TURN_LEFT/TURN_RIGHT/U_TURN/PICK_BOX into ramped PWM and direction for the left and right motors.
- Sequences timed U-turns and the gripper handshake for box pickup, and reports completion and faults back to the navigation layer.

Parameters:
PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS clocks
DUTY_FWD, 200, duty target for DRIVE_BOTH
DUTY_TURN, 128, duty target for turns and U-turn
RAMP_STEP, 16, max duty change per PWM period
UTURN_CYCLES, 50000, U-turn spin duration in clocks (24-bit counter)
PICK_TIMEOUT, 100000, max clocks waiting for gripper_ack (24-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
state  in  3  navigation state: 000 IDLE, 001 DRIVE_BOTH, 010 TURN_LEFT, 011 TURN_RIGHT, 100 U_TURN, 101 PICK_BOX, 110/111 invalid
gripper_ack  in  1  gripper closed on box, level
pwm_left  out  1  left motor PWM
pwm_right  out  1  right motor PWM
dir_left  out  1  left direction, 1 = forward
dir_right  out  1  right direction, 1 = forward
gripper_cmd  out  1  close gripper, level
action_done  out  1  one-cycle pulse: U-turn or pickup finished
fault  out  1  sticky: pickup timeout or invalid state seen

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0 except dir_left=dir_right=1. Duty registers, pwm_cnt, counters and fault cleared. Sequencer enters SEQ_IDLE.
- Targets per state (side: direction, duty):
  - IDLE: both 0.
  - DRIVE_BOTH: both forward, DUTY_FWD.
  - TURN_LEFT: left 0; right forward, DUTY_TURN.
  - TURN_RIGHT: left forward, DUTY_TURN; right 0.
  - U_TURN (while SEQ_UTURN): left reverse, DUTY_TURN; right forward, DUTY_TURN. Otherwise both 0.
  - PICK_BOX: both 0.
  - 110/111: both 0; fault set.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps.
  - pwm_x is registered and equals (pwm_cnt < duty_x), so it lags by 1 clock.
  - Duty 0 gives constant low. Duty 2^PWM_BITS-1 gives low for exactly 1 clock per period.
- Ramp, evaluated only when pwm_cnt == max:
  - If dir_x equals the target direction: duty steps toward the target by at most RAMP_STEP, saturating exactly at the target with no overshoot.
  - If dir_x differs from the target direction: duty ramps down to 0 first. dir_x flips at the period end where duty is already 0. Ramp-up starts the following period.
- Sequencer states: SEQ_IDLE, SEQ_UTURN, SEQ_PICK_STOP, SEQ_PICK_GRIP, SEQ_HOLD.
  - SEQ_IDLE, state==100: clear counter, go to SEQ_UTURN.
  - SEQ_IDLE, state==101: go to SEQ_PICK_STOP.
  - SEQ_UTURN: counter increments each clock. At count UTURN_CYCLES-1, pulse action_done and go to SEQ_HOLD (motor targets become 0).
  - SEQ_PICK_STOP: when both duties == 0, assert gripper_cmd, clear timeout counter, go to SEQ_PICK_GRIP.
  - SEQ_PICK_GRIP: gripper_cmd held high.
    - gripper_ack=1: pulse action_done on the next clock; gripper_cmd stays high; go to SEQ_HOLD.
    - Counter reaches PICK_TIMEOUT-1 with no ack: set fault, drop gripper_cmd, go to SEQ_HOLD, no action_done.
  - SEQ_HOLD: stays until state differs from the state that started the action, then goes to SEQ_IDLE. gripper_cmd clears on that exit. This prevents retrigger while the controller still presents 100/101.
- Abort: if state changes while in SEQ_UTURN, SEQ_PICK_STOP or SEQ_PICK_GRIP:
  - Go to SEQ_IDLE the next clock.
  - gripper_cmd drops, counters clear, no action_done.
  - Motors ramp to the new state's targets.
- Simultaneous gripper_ack and timeout terminal count: ack wins; no fault.
- fault clears only on reset.

Test Plan:
- Reset, then state=001: duty ramps 0→16→…→192→200 over 13 periods; pwm_left high 200 of 256 clocks in steady state; dir both 1.
- DRIVE_BOTH steady, then state=100: left duty ramps to 0, dir_left→0 at that period end, left ramps to 128 reverse; right settles to 128 forward; action_done pulses exactly once after UTURN_CYCLES; no second pulse while state holds 100.
- state=101 from DRIVE_BOTH: gripper_cmd rises only after both duties reach 0; gripper_ack raised 10 clocks later → action_done one pulse; gripper_cmd clears when state returns to 000.
- state=101, gripper_ack held 0: fault=1 exactly PICK_TIMEOUT clocks after gripper_cmd rose; gripper_cmd=0; no action_done; fault persists through state changes until reset.
- state=100 mid-spin changed to 000: no action_done, duties ramp to 0, sequencer back in SEQ_IDLE; a new state=100 restarts the full count.
- state=110: fault=1, motors ramp to 0. Assert reset mid-ramp: all outputs return to reset values immediately, without waiting for a clock edge.
